// File: rtl/sm3_pkg.sv
// Shared types and constants for the SM3 message-input arbiter.
//   arb_st_t      : arbiter FSM state encoding
//   ARB_N_REQ_MAX : largest supported requester count
package sm3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STRM = 2'd1,
    WAIT = 2'd2
  } arb_st_t;

  localparam int ARB_N_REQ_MAX = 8;

endpackage

// File: rtl/sm3_msg_if.sv
// Message-input bus between the arbiter and the SM3 pad stage.
//   d        : beat data
//   vld_byte : byte valid, meaningful on the last beat
//   vld      : beat valid
//   lst      : last beat of the message
//   rdy      : pad can take the beat
// Handshake: a beat moves exactly on a cycle where vld && rdy are both 1.
// vld does not wait for rdy, and once vld is raised the beat is held
// unchanged until it is taken.
interface sm3_msg_if #(
  parameter int DW = 32
);
  logic [DW-1:0]   d;
  logic [DW/8-1:0] vld_byte;
  logic            vld;
  logic            lst;
  logic            rdy;

  modport arb (output d, vld_byte, vld, lst, input rdy);
  modport pad (input d, vld_byte, vld, lst, output rdy);
endinterface

// File: rtl/sm3_rr_pick.sv
// Combinational round-robin picker.
//   req : request vector, one bit per requester
//   ptr : highest-priority requester this round
//   any : at least one request is set
//   idx : first set request found scanning ptr, ptr+1, ... wrapping at N_REQ
module sm3_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             any,
  output logic [IW-1:0]    idx
);

  // The vector is doubled so the wrap-around becomes a plain linear scan of
  // the window [ptr, ptr+N_REQ).
  logic [2*N_REQ-1:0] dbl;
  logic               found;

  always_comb begin
    dbl   = {req, req};
    any   = |req;
    idx   = '0;
    found = 1'b0;
    for (int j = 0; j < 2 * N_REQ; j++) begin
      if (!found && (j >= int'(ptr)) && (j < int'(ptr) + N_REQ) && dbl[j]) begin
        found = 1'b1;
        idx   = IW'(j % N_REQ);
      end
    end
  end

endmodule

// File: rtl/sm3_msg_arb.sv
// Round-robin arbiter sharing one SM3 core among N_REQ message sources.
// A requester owns the pad input for a whole message. The grant is released
// on the accepted last beat, or on the following cmprss_done_i pulse when
// WAIT_DONE_EN=1.
//   req_d_i / req_vld_byte_i / req_vld_i / req_lst_i : requester channels
//   req_rdy_o      : per-requester beat accept, only the owner can see 1
//   msg_inpt_*_o   : beat presented to the pad, muxed from the owner
//   msg_inpt_rdy_i : pad ready
//   cmprss_done_i  : digest-valid pulse for the current message
//   gnt_id_o       : current or most recent owner, used for digest routing
//   busy_o         : arbiter is not idle
module sm3_msg_arb
  import sm3_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int INPT_DW      = 32,
  parameter int WAIT_DONE_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ*INPT_DW-1:0]   req_d_i,
  input  logic [N_REQ*INPT_DW/8-1:0] req_vld_byte_i,
  input  logic [N_REQ-1:0]           req_vld_i,
  input  logic [N_REQ-1:0]           req_lst_i,
  output logic [N_REQ-1:0]           req_rdy_o,
  output logic [INPT_DW-1:0]         msg_inpt_d_o,
  output logic [INPT_DW/8-1:0]       msg_inpt_vld_byte_o,
  output logic                       msg_inpt_vld_o,
  output logic                       msg_inpt_lst_o,
  input  logic                       msg_inpt_rdy_i,
  input  logic                       cmprss_done_i,
  output logic [$clog2(N_REQ)-1:0]   gnt_id_o,
  output logic                       busy_o
);

  localparam int IW = $clog2(N_REQ);
  localparam int BW = INPT_DW / 8;

  arb_st_t       state, state_nxt;
  logic [IW-1:0] gnt_id, rr_ptr, pick_idx;
  logic          pick_any;
  logic          gnt_vld, gnt_lst, msg_end;
  logic          out_vld, out_lst;
  logic [N_REQ-1:0] rdy_vec;

  sm3_msg_if #(.DW(INPT_DW)) pad_if ();

  sm3_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req (req_vld_i),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign gnt_vld = req_vld_i[gnt_id];
  assign gnt_lst = req_lst_i[gnt_id];
  assign msg_end = (state == STRM) && gnt_vld && gnt_lst && msg_inpt_rdy_i;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state. A done pulse seen in IDLE or STRM (including the cycle the
  // last beat is taken) is deliberately ignored; WAIT needs its own pulse.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pick_any) state_nxt = STRM;
      STRM: if (msg_end)  state_nxt = (WAIT_DONE_EN != 0) ? WAIT : IDLE;
      WAIT: if (cmprss_done_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant and round-robin pointer. The pointer moves only on a completed
  // message, so an aborted message does not cost its owner its turn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_id <= '0;
      rr_ptr <= '0;
    end else begin
      if (state == IDLE && pick_any) gnt_id <= pick_idx;
      if (msg_end) rr_ptr <= (gnt_id == IW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Outputs
  always_comb begin
    out_vld = 1'b0;
    out_lst = 1'b0;
    rdy_vec = '0;
    if (state == STRM) begin
      out_vld         = gnt_vld;
      out_lst         = gnt_lst;
      rdy_vec[gnt_id] = msg_inpt_rdy_i;
    end
  end

  assign pad_if.d        = req_d_i[int'(gnt_id) * INPT_DW +: INPT_DW];
  assign pad_if.vld_byte = req_vld_byte_i[int'(gnt_id) * BW +: BW];
  assign pad_if.vld      = out_vld;
  assign pad_if.lst      = out_lst;
  assign pad_if.rdy      = msg_inpt_rdy_i;

  assign msg_inpt_d_o        = pad_if.d;
  assign msg_inpt_vld_byte_o = pad_if.vld_byte;
  assign msg_inpt_vld_o      = pad_if.vld;
  assign msg_inpt_lst_o      = pad_if.lst;
  assign req_rdy_o           = pad_if.rdy ? rdy_vec : '0;
  assign gnt_id_o            = gnt_id;
  assign busy_o              = (state != IDLE);

endmodule

// File: tb/tb_sm3_msg_arb.sv
module tb_sm3_msg_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int W  = 39;   // {id[1:0], lst, vld_byte[3:0], data[31:0]}

  typedef logic [36:0] beat_t;  // {lst, vld_byte, data}

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] req_d;
  logic [N*BW-1:0] req_vb;
  logic [N-1:0]    req_vld, req_lst;
  logic            pad_rdy, done;

  logic [N-1:0]    req_rdy_o,  req_rdy0;
  logic [DW-1:0]   msg_d,      msg_d0;
  logic [BW-1:0]   msg_vb,     msg_vb0;
  logic            msg_vld,    msg_vld0;
  logic            msg_lst,    msg_lst0;
  logic [1:0]      gnt,        gnt0;
  logic            busy,       busy0;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  sm3_msg_arb #(.N_REQ(N), .INPT_DW(DW), .WAIT_DONE_EN(1)) dut (
    .clk(clk), .rst(rst), .req_d_i(req_d), .req_vld_byte_i(req_vb),
    .req_vld_i(req_vld), .req_lst_i(req_lst), .req_rdy_o(req_rdy_o),
    .msg_inpt_d_o(msg_d), .msg_inpt_vld_byte_o(msg_vb),
    .msg_inpt_vld_o(msg_vld), .msg_inpt_lst_o(msg_lst),
    .msg_inpt_rdy_i(pad_rdy), .cmprss_done_i(done),
    .gnt_id_o(gnt), .busy_o(busy)
  );

  sm3_msg_arb #(.N_REQ(N), .INPT_DW(DW), .WAIT_DONE_EN(0)) dut0 (
    .clk(clk), .rst(rst), .req_d_i(req_d), .req_vld_byte_i(req_vb),
    .req_vld_i(req_vld), .req_lst_i(req_lst), .req_rdy_o(req_rdy0),
    .msg_inpt_d_o(msg_d0), .msg_inpt_vld_byte_o(msg_vb0),
    .msg_inpt_vld_o(msg_vld0), .msg_inpt_lst_o(msg_lst0),
    .msg_inpt_rdy_i(pad_rdy), .cmprss_done_i(done),
    .gnt_id_o(gnt0), .busy_o(busy0)
  );

  // ---------------- clock / reset / driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    req_d   = '0;
    req_vb  = '0;
    req_vld = '0;
    req_lst = '0;
    pad_rdy = 1'b0;
    done    = 1'b0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drive_req(input int i, input logic v, input logic l,
                           input logic [DW-1:0] d, input logic [BW-1:0] vb);
    req_vld[i]         = v;
    req_lst[i]         = l;
    req_d[i*DW +: DW]  = d;
    req_vb[i*BW +: BW] = vb;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clr_inputs();
    rst = 1'b1;
    req_vld = 4'hF;
    pad_rdy = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || gnt !== 2'd0 || req_rdy_o !== 4'h0 || msg_vld !== 1'b0 || msg_lst !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b gnt=%0d rdy=%b vld=%b lst=%b required 0 0 0000 0 0",
               busy, gnt, req_rdy_o, msg_vld, msg_lst);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_single_msg();
    do_reset();
    pad_rdy = 1'b1;
    drive_req(0, 1'b1, 1'b0, 32'h61626380, 4'hF);
    @(negedge clk);
    total++;
    if (msg_vld !== 1'b0 || req_rdy_o !== 4'h0) begin
      bad++;
      $display("FAIL idle_no_accept: vld=%b rdy=%b required 0 0000", msg_vld, req_rdy_o);
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        step();
        drive_req(0, 1'b1, k == 2, 32'h0, 4'hF);
      end else begin
        step();
      end
      @(negedge clk);
      total++;
      if (gnt !== 2'd0 || msg_vld !== 1'b1 || msg_d !== ((k == 0) ? 32'h61626380 : 32'h0) ||
          msg_lst !== (k == 2) || req_rdy_o !== 4'b0001) begin
        bad++;
        $display("FAIL single_beat%0d: gnt=%0d vld=%b d=%h lst=%b rdy=%b", k, gnt, msg_vld, msg_d, msg_lst, req_rdy_o);
      end
    end
    step();
    drive_req(0, 1'b0, 1'b0, 32'h0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || req_rdy_o !== 4'h0 || msg_vld !== 1'b0 || gnt !== 2'd0) begin
        bad++;
        $display("FAIL wait_hold%0d: busy=%b rdy=%b vld=%b gnt=%0d required 1 0000 0 0", k, busy, req_rdy_o, msg_vld, gnt);
      end
      step();
    end
    done = 1'b1;
    step();
    done = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL wait_release: busy=%b required 0", busy);
    end
    // pointer is now 1: with req0 and req1 both asking, req1 wins
    drive_req(0, 1'b1, 1'b1, 32'h0, 4'hF);
    drive_req(1, 1'b1, 1'b1, 32'h11, 4'hF);
    step();
    @(negedge clk);
    total++;
    if (gnt !== 2'd1) begin
      bad++;
      $display("FAIL rr_ptr_after_msg: gnt=%0d required 1", gnt);
    end
  endtask

  task automatic test_round_robin();
    int cyc;
    do_reset();
    pad_rdy = 1'b1;
    for (int i = 0; i < N; i++) drive_req(i, 1'b1, 1'b1, 32'hA0 + i, 4'hF);
    for (int m = 0; m < 5; m++) begin
      cyc = 0;
      @(negedge clk);
      while (msg_vld !== 1'b1 && cyc < 20) begin
        step();
        @(negedge clk);
        cyc++;
      end
      total++;
      if (cyc >= 20 || gnt !== 2'(m % N) || msg_d !== 32'(32'hA0 + m % N) || req_rdy_o !== 4'(1 << (m % N))) begin
        bad++;
        $display("FAIL rr_order%0d: gnt=%0d d=%h rdy=%b required gnt=%0d", m, gnt, msg_d, req_rdy_o, m % N);
      end
      step();
      step();
      step();
      done = 1'b1;
      step();
      done = 1'b0;
    end
  endtask

  task automatic test_owner_gap();
    do_reset();
    pad_rdy = 1'b1;
    drive_req(2, 1'b1, 1'b0, 32'h22, 4'hF);
    step();
    @(negedge clk);
    total++;
    if (gnt !== 2'd2 || msg_vld !== 1'b1) begin
      bad++;
      $display("FAIL gap_grant: gnt=%0d vld=%b required 2 1", gnt, msg_vld);
    end
    step();
    drive_req(2, 1'b0, 1'b0, 32'h23, 4'hF);
    drive_req(1, 1'b1, 1'b1, 32'h11, 4'hF);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (msg_vld !== 1'b0 || req_rdy_o[1] !== 1'b0 || gnt !== 2'd2 || busy !== 1'b1) begin
        bad++;
        $display("FAIL gap_cycle%0d: vld=%b rdy1=%b gnt=%0d busy=%b required 0 0 2 1", k, msg_vld, req_rdy_o[1], gnt, busy);
      end
      step();
    end
    drive_req(2, 1'b1, 1'b1, 32'h23, 4'hF);
    @(negedge clk);
    total++;
    if (msg_vld !== 1'b1 || msg_lst !== 1'b1 || msg_d !== 32'h23 || gnt !== 2'd2 || req_rdy_o !== 4'b0100) begin
      bad++;
      $display("FAIL gap_resume: vld=%b lst=%b d=%h gnt=%0d rdy=%b", msg_vld, msg_lst, msg_d, gnt, req_rdy_o);
    end
  endtask

  task automatic test_rdy_toggle();
    int   k = 0;
    logic tog = 1'b1;
    do_reset();
    for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
      drive_req(3, 1'b1, k == 3, 32'h300 + k, (k == 3) ? 4'b1110 : 4'hF);
      pad_rdy = tog;
      tog = ~tog;
      @(negedge clk);
      if (msg_vld === 1'b1 && pad_rdy === 1'b1) begin
        total++;
        if (msg_d !== 32'(32'h300 + k) || msg_lst !== (k == 3) || (k == 3 && msg_vb !== 4'b1110)) begin
          bad++;
          $display("FAIL toggle_beat%0d: d=%h lst=%b vb=%b required d=%h", k, msg_d, msg_lst, msg_vb, 32'h300 + k);
        end
        k++;
      end
      step();
    end
    total++;
    if (k != 4) begin
      bad++;
      $display("FAIL toggle_count: beats=%0d required 4", k);
    end
  endtask

  task automatic test_no_wait_mode();
    do_reset();
    pad_rdy = 1'b1;
    drive_req(1, 1'b1, 1'b1, 32'h11, 4'hF);
    drive_req(3, 1'b1, 1'b1, 32'h33, 4'hF);
    step();
    done = 1'b1;  // pulse during STRM, same cycle as the last beat
    @(negedge clk);
    total++;
    if (gnt0 !== 2'd1 || msg_vld0 !== 1'b1 || gnt !== 2'd1) begin
      bad++;
      $display("FAIL nowait_first: gnt0=%0d vld0=%b gnt=%0d required 1 1 1", gnt0, msg_vld0, gnt);
    end
    step();
    done = 1'b0;
    drive_req(1, 1'b0, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    total++;
    if (busy0 !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL nowait_release: busy0=%b busy=%b required 0 1", busy0, busy);
    end
    step();
    @(negedge clk);
    total++;
    if (gnt0 !== 2'd3 || msg_vld0 !== 1'b1 || msg_d0 !== 32'h33 || busy !== 1'b1 || gnt !== 2'd1 || req_rdy_o !== 4'h0) begin
      bad++;
      $display("FAIL nowait_second: gnt0=%0d vld0=%b d0=%h busy=%b gnt=%0d rdy=%b", gnt0, msg_vld0, msg_d0, busy, gnt, req_rdy_o);
    end
  endtask

  task automatic test_reset_mid_msg();
    do_reset();
    pad_rdy = 1'b1;
    drive_req(1, 1'b1, 1'b1, 32'h11, 4'hF);
    step();
    step();
    drive_req(1, 1'b0, 1'b0, 32'h0, 4'h0);
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    drive_req(2, 1'b1, 1'b0, 32'h22, 4'hF);
    step();
    @(negedge clk);
    total++;
    if (gnt !== 2'd2 || busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_grant: gnt=%0d busy=%b required 2 1", gnt, busy);
    end
    step();
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || req_rdy_o !== 4'h0 || gnt !== 2'd0 || msg_vld !== 1'b0) begin
      bad++;
      $display("FAIL midrst_outputs: busy=%b rdy=%b gnt=%0d vld=%b required 0 0000 0 0", busy, req_rdy_o, gnt, msg_vld);
    end
    step();
    rst = 1'b0;
    drive_req(0, 1'b1, 1'b1, 32'h00, 4'hF);
    step();
    @(negedge clk);
    total++;
    if (gnt !== 2'd0) begin
      bad++;
      $display("FAIL midrst_rearb: gnt=%0d required 0", gnt);
    end
  endtask

  // Random traffic. A requester holds its first beat valid from the moment a
  // message is pending, so at every arbitration point the set of asking
  // requesters is exactly those with messages left; the service order is then
  // plain round robin over the pending-message counts.
  task automatic test_random();
    beat_t req_q[N][$];
    int    len_q[N][$];
    beat_t mdl_q[N][$];
    logic  started[N];
    int    ptr, id, len, cyc, dly;
    logic  pend_done;
    beat_t b;
    logic [W-1:0] e;

    do_reset();
    for (int i = 0; i < N; i++) begin
      int nmsg = (i == 0) ? $urandom_range(1, 4) : $urandom_range(0, 4);
      started[i] = 1'b0;
      for (int m = 0; m < nmsg; m++) begin
        len = $urandom_range(1, 4);
        len_q[i].push_back(len);
        for (int k = 0; k < len; k++) begin
          logic [3:0] vb = (k == len - 1) ? 4'($urandom_range(1, 15)) : 4'hF;
          b = {k == len - 1, vb, 32'($urandom)};
          req_q[i].push_back(b);
          mdl_q[i].push_back(b);
        end
      end
    end

    ptr = 0;
    forever begin
      id = -1;
      for (int k = 0; k < N; k++)
        if (id < 0 && len_q[(ptr + k) % N].size() > 0) id = (ptr + k) % N;
      if (id < 0) break;
      len = len_q[id].pop_front();
      for (int k = 0; k < len; k++) begin
        b = mdl_q[id].pop_front();
        exp_q.push_back({2'(id), b});
      end
      ptr = (id + 1) % N;
    end

    pend_done = 1'b0;
    dly = 0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      step();
      cyc++;
      done = 1'b0;
      if (pend_done) begin
        if (dly == 0) begin
          done = 1'b1;
          pend_done = 1'b0;
        end else dly--;
      end
      for (int i = 0; i < N; i++) begin
        if (req_q[i].size() > 0) begin
          b = req_q[i][0];
          drive_req(i, started[i] ? ($urandom_range(0, 3) != 0) : 1'b1, b[36], b[31:0], b[35:32]);
        end else drive_req(i, 1'b0, 1'b0, 32'h0, 4'h0);
      end
      pad_rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      total++;
      if ((req_rdy_o & ~(4'b0001 << gnt)) !== 4'h0) begin
        bad++;
        $display("FAIL rand_rdy_owner: rdy=%b gnt=%0d", req_rdy_o, gnt);
      end
      if (msg_vld === 1'b1 && pad_rdy === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rand_extra_beat: d=%h gnt=%0d required none", msg_d, gnt);
        end else begin
          e = exp_q.pop_front();
          if (gnt !== e[38:37] || msg_lst !== e[36] || msg_d !== e[31:0] || (e[36] && msg_vb !== e[35:32])) begin
            bad++;
            $display("FAIL rand_beat: gnt=%0d lst=%b vb=%b d=%h required gnt=%0d lst=%b vb=%b d=%h",
                     gnt, msg_lst, msg_vb, msg_d, e[38:37], e[36], e[35:32], e[31:0]);
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_rdy_o[i] === 1'b1 && req_vld[i] === 1'b1 && req_q[i].size() > 0) begin
          b = req_q[i].pop_front();
          started[i] = ~b[36];
          if (b[36]) begin
            pend_done = 1'b1;
            dly = $urandom_range(0, 3);
          end
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rand_timeout: %0d beats left after %0d cycles, required 0", exp_q.size(), cyc);
    end
  endtask

  initial begin
    rst = 1'b1;
    clr_inputs();
    test_reset();
    test_single_msg();
    test_round_robin();
    test_owner_gap();
    test_rdy_toggle();
    test_no_wait_mode();
    test_reset_mid_msg();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
